// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline-stage register: default widths,
// EX/MEM field positions and the occupancy state encoding.
package pipe_pkg;

    localparam int DEF_DATA_W     = 32;
    localparam int DEF_NUM_FIELDS = 5;
    localparam int DEF_FLAG_W     = 1;
    localparam int DEF_CNT_W      = 16;

    // Field slots of the EX/MEM bundle inside in_data/out_data.
    localparam int F_ALU   = 0;
    localparam int F_STORE = 1;
    localparam int F_WREG  = 2;
    localparam int F_BRTGT = 3;

    // Encoded as {main_valid, skid_valid}; 2'b01 cannot occur.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_BUSY  = 2'b10,
        ST_FULL  = 2'b11
    } pipe_state_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at its all-ones value; cleared only by reset.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline-stage register: main entry plus one skid entry so that
// in_ready comes straight from a flop, with flush and a stall-cycle counter.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int NUM_FIELDS = DEF_NUM_FIELDS,
    parameter int FLAG_W     = DEF_FLAG_W,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [NUM_FIELDS*DATA_W-1:0] in_data,
    input  logic [FLAG_W-1:0]            in_flags,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [NUM_FIELDS*DATA_W-1:0] out_data,
    output logic [FLAG_W-1:0]            out_flags,
    output logic [CNT_W-1:0]             stall_cnt
);

    localparam int BUS_W = NUM_FIELDS * DATA_W;

    logic              main_valid;
    logic [BUS_W-1:0]  main_data;
    logic [FLAG_W-1:0] main_flags;
    logic              skid_valid;
    logic [BUS_W-1:0]  skid_data;
    logic [FLAG_W-1:0] skid_flags;

    logic        push;
    logic        pop;
    pipe_state_t state;

    // Handshake: a bundle moves on a rising edge when valid and ready are both
    // high in that cycle; valid never waits on ready, and an offered output
    // bundle stays put (data and flags stable) until it is taken.
    assign in_ready  = !skid_valid;
    assign out_valid = main_valid;
    assign out_data  = main_data;
    assign out_flags = main_flags;

    assign push  = in_valid && in_ready;
    assign pop   = out_valid && out_ready;
    assign state = pipe_state_t'({main_valid, skid_valid});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid <= 1'b0;
            main_data  <= '0;
            main_flags <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            skid_flags <= '0;
        end else if (flush) begin
            // Squash both entries; payload registers keep their old contents.
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (push) begin
                        main_valid <= 1'b1;
                        main_data  <= in_data;
                        main_flags <= in_flags;
                    end
                end
                ST_BUSY: begin
                    if (push && pop) begin
                        main_data  <= in_data;
                        main_flags <= in_flags;
                    end else if (pop) begin
                        main_valid <= 1'b0;
                    end else if (push) begin
                        skid_valid <= 1'b1;
                        skid_data  <= in_data;
                        skid_flags <= in_flags;
                    end
                end
                ST_FULL: begin
                    if (pop) begin
                        main_data  <= skid_data;
                        main_flags <= skid_flags;
                        skid_valid <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    sat_counter #(
        .W(CNT_W)
    ) u_stall_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .inc  (out_valid && !out_ready),
        .count(stall_cnt)
    );

endmodule
